banner_scroller: RTL and testbench
==================================

BANNER_SCROLLER -- requirements
Module: banner_scroller

Interface
REQ-001 Parameter WIDTH, default 57: bits per banner column (ROM word width).
REQ-002 Parameter DEPTH, default 129: number of banner columns held in the ROM; legal range 2..256.
REQ-003 Parameter WIN, default 32: visible display columns; legal range 1..DEPTH.
REQ-004 Parameter TICK_DIV, default 2500000: clk cycles per scroll step; legal minimum 1.
REQ-005 Derived widths: AW = clog2(DEPTH) for addresses and offset; CW = clog2(WIN), minimum 1, for column index.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 start  in  1  one-cycle pulse; begins scrolling from offset 0.
REQ-009 pause  in  1  level; when high, scroll steps are held.
REQ-010 mode  in  1  0 = loop (wrap forever), 1 = one-shot (stop at end).
REQ-011 dir  in  1  0 = offset increments, 1 = offset decrements.
REQ-012 frame_sync  in  1  one-cycle pulse at display frame boundary.
REQ-013 col_req  in  1  column lookup request, one per cycle allowed.
REQ-014 col_idx  in  CW  display column requested, 0..WIN-1.
REQ-015 rom_addr  out  AW  combinational address to an external ROM with 1-cycle registered-address latency.
REQ-016 rom_data  in  WIDTH  ROM word for the address presented in the previous cycle.
REQ-017 col_data  out  WIDTH  registered column pixels.
REQ-018 col_valid  out  1  col_data holds the result of a request.
REQ-019 offset  out  AW  current scroll offset.
REQ-020 busy  out  1  high in RUN or PAUSE.
REQ-021 done  out  1  one-cycle pulse on entry to DONE.

Function
REQ-022 States: IDLE, RUN, PAUSE, DONE.
REQ-023 Transitions: start in any state -> RUN with offset 0, tick counter 0, step_pending cleared; RUN with pause high -> PAUSE; PAUSE with pause low -> RUN; RUN one-shot end condition -> DONE.
REQ-024 start wins over pause in the same cycle; entry to RUN is followed by PAUSE on the next cycle if pause is still high.
REQ-025 Tick counter runs only in RUN, counts 0..TICK_DIV-1, and sets step_pending on wrap; it holds its value in PAUSE.
REQ-026 Steps are applied only on frame_sync: when step_pending and frame_sync are both high in RUN, the offset steps by one and step_pending clears.
REQ-027 Tick wrap coincident with a frame_sync that applies a pending step leaves step_pending set; there is at most one pending step.
REQ-028 Loop mode, dir 0: offset wraps from DEPTH-1 to 0.
REQ-029 Loop mode, dir 1: offset wraps from 0 to DEPTH-1.
REQ-030 One-shot mode, dir 0: the step that makes offset equal DEPTH-WIN enters DONE.
REQ-031 One-shot mode, dir 1: the first step from offset 0 goes to DEPTH-WIN; the step that reaches 0 enters DONE.
REQ-032 In DONE the offset holds, busy is 0, and a single done pulse is asserted.
REQ-033 Address computation: sum = offset + col_idx; rom_addr = sum, or sum - DEPTH if sum >= DEPTH, using a single conditional subtract.
REQ-034 col_idx >= WIN is treated as blank and produces zero data.
REQ-035 Lookup latency: col_req in cycle N -> rom_addr valid in N -> rom_data captured into col_data at the end of N+1 -> col_valid high in N+2.
REQ-036 col_valid follows col_req delayed by exactly 2 cycles, including back-to-back requests at full throughput.
REQ-037 Lookups are served in every state, using the offset registered in the request cycle.
REQ-038 An offset change while lookups are in flight does not alter those in-flight results.
REQ-039 col_data is zero for blank requests and holds its last value when col_valid is low.
REQ-040 mode and dir are sampled on every step; a change takes effect at the next step.

Reset
REQ-041 On rst: state IDLE, offset 0, tick counter 0, step_pending 0, col_data 0, col_valid 0, done 0, busy 0, and the lookup pipeline is cleared.
REQ-042 rst asserted mid-operation aborts any in-flight lookup; no col_valid appears after rst is released.

Verification
Bench parameters: WIDTH=8, DEPTH=8, WIN=4, TICK_DIV=3, ROM word = 8'h10+address.
REQ-043 Loop scroll: start, mode 0, dir 0, frame_sync every cycle -> offset 0,1,..,7,0 with one step every 3 cycles; busy stays 1.
REQ-044 Lookup: offset=6, col_req with col_idx 0,1,2,3 on consecutive cycles -> col_data 16,17,10,11 (hex) on cycles N+2..N+5, col_valid high for 4 cycles.
REQ-045 One-shot: mode 1, dir 0 -> offset stops at 4, single done pulse, busy 0; later pending ticks do not change offset.
REQ-046 Reverse one-shot: mode 1, dir 1 -> offset 0,4,3,2,1,0, then DONE.
REQ-047 Frame gating: frame_sync every 10 cycles -> offset advances at most once per frame_sync; pause held 20 cycles -> no step and tick counter frozen.
REQ-048 Reset mid-lookup: rst in cycle N+1 of a request -> col_valid stays 0 and every output is at its reset value, while start and pause are both high.

Source files
------------

// File: rtl/banner_scroller.sv
// Banner scroller: steps a scroll offset through a column ROM on a tick/frame
// cadence and serves display-column lookups through a two-stage pipeline that
// matches an external ROM with a registered address.
//
// Handshake: col_req is a single-cycle request with no back-pressure. A request
// in cycle N drives rom_addr in cycle N. rom_data is captured at the end of
// cycle N+1, and col_valid is high for exactly one cycle, in cycle N+2.
// Any number of back-to-back requests is accepted, one per cycle.
module banner_scroller #(
  parameter int WIDTH    = 57,
  parameter int DEPTH    = 129,
  parameter int WIN      = 32,
  parameter int TICK_DIV = 2500000,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = (WIN > 1) ? $clog2(WIN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             mode,
  input  logic             dir,
  input  logic             frame_sync,
  input  logic             col_req,
  input  logic [CW-1:0]    col_idx,
  output logic [AW-1:0]    rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] col_data,
  output logic             col_valid,
  output logic [AW-1:0]    offset,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] OFF_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] OFF_END   = AW'(DEPTH - WIN);
  localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DEPTH);
  localparam logic [CW:0]   WIN_X     = (CW + 1)'(WIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   offset_q, offset_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic            pend_q, pend_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   step_off;
  logic            step_last;
  logic            tick_wrap;
  logic            step_en;

  logic [AW:0]     addr_sum;
  logic            blank_now;
  logic            req_q, blank_q;
  logic            col_valid_q;
  logic [WIDTH-1:0] col_data_q, col_data_d;

  // Offset one step ahead in the current direction, and whether that step
  // finishes a one-shot scroll.
  always_comb begin
    step_off  = offset_q;
    step_last = 1'b0;
    if (!dir) begin
      step_off  = (offset_q == OFF_LAST) ? '0 : offset_q + AW'(1);
      step_last = mode && (step_off == OFF_END);
    end else begin
      if (offset_q == '0) begin
        // One-shot reverse jumps to the last full window rather than DEPTH-1.
        step_off = mode ? OFF_END : OFF_LAST;
      end else begin
        step_off = offset_q - AW'(1);
      end
      step_last = mode && (step_off == '0);
    end
  end

  // Scroll control: start restarts from anywhere; ticks accrue only while
  // running, and a pending step is applied only on a frame boundary.
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    tick_d    = tick_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    tick_wrap = (tick_q == TICK_LAST);
    step_en   = 1'b0;
    if (start) begin
      state_d  = S_RUN;
      offset_d = '0;
      tick_d   = '0;
      pend_d   = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else begin
            tick_d  = tick_wrap ? '0 : tick_q + TW'(1);
            step_en = pend_q && frame_sync;
            // A wrap in the same cycle as an applied step re-arms one step.
            pend_d  = tick_wrap || (pend_q && !step_en);
            if (step_en) begin
              offset_d = step_off;
              if (step_last) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        S_PAUSE: begin
          if (!pause) state_d = S_RUN;
        end
        default: ;
      endcase
    end
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

  // Scroll state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      offset_q <= '0;
      tick_q   <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Lookup address (offset + column, folded once into the ROM range) and the
  // capture of the ROM word one cycle after the request.
  always_comb begin
    addr_sum  = {1'b0, offset_q} + (AW + 1)'(col_idx);
    rom_addr  = (addr_sum >= DEPTH_X) ? AW'(addr_sum - DEPTH_X) : addr_sum[AW-1:0];
    blank_now = ({1'b0, col_idx} >= WIN_X);
    col_data_d = col_data_q;
    if (req_q) col_data_d = blank_q ? '0 : rom_data;
  end

  // Lookup pipeline registers; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= 1'b0;
      blank_q     <= 1'b0;
      col_valid_q <= 1'b0;
      col_data_q  <= '0;
    end else begin
      req_q       <= col_req;
      blank_q     <= blank_now;
      col_valid_q <= req_q;
      col_data_q  <= col_data_d;
    end
  end

  assign offset    = offset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign col_data  = col_data_q;
  assign col_valid = col_valid_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_banner_scroller.sv
// Bench for banner_scroller with an 8-column ROM holding 8'h10+address,
// a 4-column window and a 3-cycle tick.
module tb_banner_scroller;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 8;
  localparam int WIN      = 4;
  localparam int TICK_DIV = 3;
  localparam int AW       = 3;
  localparam int CW       = 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic             pause;
  logic             mode;
  logic             dir;
  logic             frame_sync;
  logic             col_req;
  logic [CW-1:0]    col_idx;
  logic [AW-1:0]    rom_addr;
  logic [WIDTH-1:0] rom_data;
  logic [WIDTH-1:0] col_data;
  logic             col_valid;
  logic [AW-1:0]    offset;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  banner_scroller #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .WIN(WIN), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .mode(mode), .dir(dir),
    .frame_sync(frame_sync), .col_req(col_req), .col_idx(col_idx),
    .rom_addr(rom_addr), .rom_data(rom_data), .col_data(col_data),
    .col_valid(col_valid), .offset(offset), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // Clock and the external ROM (registered address, one-cycle latency).
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= 8'h10 + {5'b0, rom_addr};

  int n_checks;
  int n_pass;

  // Behavioural reference: scroll position, ticks elapsed while running,
  // at most one owed step, and a scoreboard of expected lookup words.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t          m_state;
  int               m_off;
  int               m_ticks;
  bit               m_pend;
  bit               m_done;
  bit               m_s1;
  bit               m_valid;
  logic [WIDTH-1:0] m_last;
  logic [WIDTH-1:0] exp_q[$];

  function automatic bit m_busy();
    return (m_state == M_RUN) || (m_state == M_PAUSE);
  endfunction

  function automatic logic [WIDTH-1:0] m_lookup(int off, int idx);
    if (idx >= WIN) return '0;
    return WIDTH'(16 + ((off + idx) % DEPTH));
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_off = 0; m_ticks = 0; m_pend = 0; m_done = 0;
    m_s1 = 0; m_valid = 0; m_last = '0;
    exp_q.delete();
  endtask

  task automatic model_step_offset();
    if (!mode) begin
      m_off = dir ? (m_off + DEPTH - 1) % DEPTH : (m_off + 1) % DEPTH;
    end else if (!dir) begin
      m_off = (m_off + 1) % DEPTH;
      if (m_off == DEPTH - WIN) begin m_state = M_DONE; m_done = 1; end
    end else begin
      m_off = (m_off == 0) ? DEPTH - WIN : m_off - 1;
      if (m_off == 0) begin m_state = M_DONE; m_done = 1; end
    end
  endtask

  task automatic model_edge();
    bit wrapped;
    bit stepped;
    if (rst) return;
    m_valid = m_s1;
    if (m_valid) m_last = exp_q.pop_front();
    m_s1 = col_req;
    if (col_req) exp_q.push_back(m_lookup(m_off, int'(col_idx)));
    m_done = 0;
    if (start) begin
      m_state = M_RUN; m_off = 0; m_ticks = 0; m_pend = 0;
    end else if (m_state == M_RUN && pause) begin
      m_state = M_PAUSE;
    end else if (m_state == M_PAUSE && !pause) begin
      m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      m_ticks++;
      wrapped = (m_ticks % TICK_DIV) == 0;
      stepped = m_pend && frame_sync;
      if (stepped) model_step_offset();
      m_pend = wrapped || (m_pend && !stepped);
    end
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic step_clk();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; pause = 0; mode = 0; dir = 0; frame_sync = 0; col_req = 0; col_idx = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({offset, busy, done, col_valid, col_data, rom_addr} !== '0)
      $display("FAIL reset_values: got off=%0d busy=%0b done=%0b vld=%0b data=%h addr=%0d, want all zero",
               offset, busy, done, col_valid, col_data, rom_addr);
    else n_pass++;
    rst = 1'b0;
    step_clk();
    n_checks++;
    if ({offset, busy, done, col_valid, col_data} !== {AW'(m_off), m_busy(), m_done, m_valid, m_last})
      $display("FAIL reset_idle: got off=%0d busy=%0b done=%0b vld=%0b data=%h, want off=%0d busy=%0b done=%0b vld=%0b data=%h",
               offset, busy, done, col_valid, col_data, m_off, m_busy(), m_done, m_valid, m_last);
    else n_pass++;
  endtask

  task automatic test_loop_scroll();
    int vals[$];
    int at[$];
    logic [AW-1:0] prev;
    mode = 0; dir = 0; frame_sync = 1; pause = 0; start = 1;
    step_clk();
    start = 0;
    prev = offset;
    for (int c = 0; c < 25; c++) begin
      step_clk();
      n_checks++;
      if ({offset, busy, done, col_valid, col_data} !== {AW'(m_off), m_busy(), m_done, m_valid, m_last})
        $display("FAIL loop_model c=%0d: got off=%0d busy=%0b done=%0b, want off=%0d busy=%0b done=%0b",
                 c, offset, busy, done, m_off, m_busy(), m_done);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL loop_busy c=%0d: got %0b, want 1", c, busy);
      else n_pass++;
      if (offset !== prev) begin vals.push_back(int'(offset)); at.push_back(c); end
      prev = offset;
    end
    n_checks++;
    if (vals.size() != DEPTH) $display("FAIL loop_step_count: got %0d, want %0d", vals.size(), DEPTH);
    else n_pass++;
    for (int k = 0; k < vals.size() && k < DEPTH; k++) begin
      n_checks++;
      if (vals[k] != (k + 1) % DEPTH || at[k] != 3 + 3 * k)
        $display("FAIL loop_sequence k=%0d: got off=%0d at c=%0d, want off=%0d at c=%0d",
                 k, vals[k], at[k], (k + 1) % DEPTH, 3 + 3 * k);
      else n_pass++;
    end
  endtask

  task automatic test_lookup();
    logic [WIDTH-1:0] want[4];
    int guard;
    want[0] = 8'h16; want[1] = 8'h17; want[2] = 8'h10; want[3] = 8'h11;
    guard = 0;
    while (offset !== AW'(6) && guard < 100) begin
      step_clk();
      guard++;
    end
    n_checks++;
    if (offset !== AW'(6)) $display("FAIL lookup_reach_offset6: got %0d, want 6", offset);
    else n_pass++;
    pause = 1;
    for (int i = 0; i < 6; i++) begin
      col_req = (i < 4);
      col_idx = (i < 4) ? CW'(i) : '0;
      step_clk();
      n_checks++;
      if ({offset, busy, done, col_valid, col_data} !== {AW'(m_off), m_busy(), m_done, m_valid, m_last})
        $display("FAIL lookup_model i=%0d: got off=%0d vld=%0b data=%h, want off=%0d vld=%0b data=%h",
                 i, offset, col_valid, col_data, m_off, m_valid, m_last);
      else n_pass++;
      n_checks++;
      if (i >= 1 && i <= 4) begin
        if (col_valid !== 1'b1 || col_data !== want[i-1])
          $display("FAIL lookup_data i=%0d: got vld=%0b data=%h, want vld=1 data=%h", i, col_valid, col_data, want[i-1]);
        else n_pass++;
      end else begin
        if (col_valid !== 1'b0) $display("FAIL lookup_idle_valid i=%0d: got %0b, want 0", i, col_valid);
        else n_pass++;
      end
    end
    col_req = 0;
    n_checks++;
    if (col_data !== 8'h11) $display("FAIL lookup_hold: got %h, want 11", col_data);
    else n_pass++;
  endtask

  task automatic test_one_shot();
    int pulses;
    pause = 0; mode = 1; dir = 0; frame_sync = 1; start = 1;
    step_clk();
    start = 0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      step_clk();
      if (done === 1'b1) pulses++;
      n_checks++;
      if ({offset, busy, done, col_valid, col_data} !== {AW'(m_off), m_busy(), m_done, m_valid, m_last})
        $display("FAIL oneshot_model c=%0d: got off=%0d busy=%0b done=%0b, want off=%0d busy=%0b done=%0b",
                 c, offset, busy, done, m_off, m_busy(), m_done);
      else n_pass++;
    end
    n_checks++;
    if (pulses != 1 || offset !== AW'(4) || busy !== 1'b0)
      $display("FAIL oneshot_end: got pulses=%0d off=%0d busy=%0b, want pulses=1 off=4 busy=0", pulses, offset, busy);
    else n_pass++;
  endtask

  task automatic test_reverse_one_shot();
    int want[5];
    int vals[$];
    int pulses;
    logic [AW-1:0] prev;
    want[0] = 4; want[1] = 3; want[2] = 2; want[3] = 1; want[4] = 0;
    mode = 1; dir = 1; frame_sync = 1; start = 1;
    step_clk();
    start = 0;
    prev = offset;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      step_clk();
      if (done === 1'b1) pulses++;
      if (offset !== prev) vals.push_back(int'(offset));
      prev = offset;
      n_checks++;
      if ({offset, busy, done, col_valid, col_data} !== {AW'(m_off), m_busy(), m_done, m_valid, m_last})
        $display("FAIL reverse_model c=%0d: got off=%0d busy=%0b done=%0b, want off=%0d busy=%0b done=%0b",
                 c, offset, busy, done, m_off, m_busy(), m_done);
      else n_pass++;
    end
    n_checks++;
    if (vals.size() != 5 || pulses != 1 || busy !== 1'b0)
      $display("FAIL reverse_end: got steps=%0d pulses=%0d busy=%0b, want steps=5 pulses=1 busy=0", vals.size(), pulses, busy);
    else n_pass++;
    for (int k = 0; k < vals.size() && k < 5; k++) begin
      n_checks++;
      if (vals[k] != want[k]) $display("FAIL reverse_sequence k=%0d: got %0d, want %0d", k, vals[k], want[k]);
      else n_pass++;
    end
  endtask

  task automatic test_frame_gating();
    logic [AW-1:0] prev;
    logic [AW-1:0] held;
    bit fs_at_edge;
    mode = 0; dir = 0; frame_sync = 0; start = 1;
    step_clk();
    start = 0;
    prev = offset;
    for (int c = 0; c < 60; c++) begin
      frame_sync = (c % 10 == 9);
      fs_at_edge = frame_sync;
      step_clk();
      frame_sync = 0;
      if (offset !== prev) begin
        n_checks++;
        if (!fs_at_edge || ((int'(offset) - int'(prev) + DEPTH) % DEPTH) != 1)
          $display("FAIL gating_step c=%0d: got %0d -> %0d fs=%0b, want single step on frame_sync", c, prev, offset, fs_at_edge);
        else n_pass++;
      end
      prev = offset;
      n_checks++;
      if ({offset, busy, done, col_valid, col_data} !== {AW'(m_off), m_busy(), m_done, m_valid, m_last})
        $display("FAIL gating_model c=%0d: got off=%0d busy=%0b, want off=%0d busy=%0b", c, offset, busy, m_off, m_busy());
      else n_pass++;
    end
    pause = 1;
    frame_sync = 1;
    held = offset;
    for (int c = 0; c < 20; c++) begin
      step_clk();
      n_checks++;
      if (offset !== held || busy !== 1'b1)
        $display("FAIL pause_hold c=%0d: got off=%0d busy=%0b, want off=%0d busy=1", c, offset, busy, held);
      else n_pass++;
    end
    pause = 0;
    for (int c = 0; c < 12; c++) begin
      step_clk();
      n_checks++;
      if ({offset, busy, done, col_valid, col_data} !== {AW'(m_off), m_busy(), m_done, m_valid, m_last})
        $display("FAIL resume_model c=%0d: got off=%0d busy=%0b, want off=%0d busy=%0b", c, offset, busy, m_off, m_busy());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    mode = 1'($urandom_range(0, 1));
    dir = 1'($urandom_range(0, 1));
    pause = 0; frame_sync = 0; start = 1;
    step_clk();
    for (int c = 0; c < 400; c++) begin
      start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      frame_sync = ($urandom_range(0, 2) == 0);
      col_req = 1'($urandom_range(0, 1));
      col_idx = CW'($urandom_range(0, WIN - 1));
      step_clk();
      n_checks++;
      if ({offset, busy, done, col_valid, col_data} !== {AW'(m_off), m_busy(), m_done, m_valid, m_last})
        $display("FAIL random_model c=%0d: got off=%0d busy=%0b done=%0b vld=%0b data=%h, want off=%0d busy=%0b done=%0b vld=%0b data=%h",
                 c, offset, busy, done, col_valid, col_data, m_off, m_busy(), m_done, m_valid, m_last);
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_lookup();
    idle_inputs();
    col_req = 1; col_idx = CW'(1);
    step_clk();
    col_req = 0; col_idx = '0;
    rst = 1; start = 1; pause = 1;
    model_reset();
    #2;
    n_checks++;
    if ({offset, busy, done, col_valid, col_data, rom_addr} !== '0)
      $display("FAIL midreset_values: got off=%0d busy=%0b done=%0b vld=%0b data=%h addr=%0d, want all zero",
               offset, busy, done, col_valid, col_data, rom_addr);
    else n_pass++;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({offset, busy, done, col_valid, col_data, rom_addr} !== '0)
        $display("FAIL midreset_held c=%0d: got off=%0d busy=%0b done=%0b vld=%0b data=%h, want all zero",
                 c, offset, busy, done, col_valid, col_data);
      else n_pass++;
    end
    rst = 0; start = 0; pause = 0;
    for (int c = 0; c < 4; c++) begin
      step_clk();
      n_checks++;
      if (col_valid !== 1'b0 || {offset, busy, done, col_data} !== {AW'(m_off), m_busy(), m_done, m_last})
        $display("FAIL midreset_after c=%0d: got vld=%0b off=%0d busy=%0b data=%h, want vld=0 off=%0d busy=%0b data=%h",
                 c, col_valid, offset, busy, col_data, m_off, m_busy(), m_last);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_loop_scroll();
    test_lookup();
    test_one_shot();
    test_reverse_one_shot();
    test_frame_gating();
    test_random();
    test_reset_mid_lookup();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
